// File: rtl/spi_burst_sequencer.sv
// Burst sequencer in front of a single-CS SPI master: replays buffered host bytes in one
// chip-select burst and buffers the replies. Define SPI_SEQ_TIMEOUT_EN for a per-byte watchdog.
module spi_burst_sequencer #(
  parameter int MAX_BYTES_PER_CS = 3,
  parameter int DEPTH            = 4,
  parameter int TIMEOUT_CLKS     = 1024,
  parameter int CW               = $clog2(MAX_BYTES_PER_CS + 1)
) (
  input  logic          i_Clk,
  input  logic          i_Rst,
  input  logic          i_Wr_DV,
  input  logic [7:0]    i_Wr_Byte,
  output logic          o_Wr_Full,
  input  logic          i_Start,
  input  logic [CW-1:0] i_Len,
  output logic          o_Busy,
  output logic          o_Done,
  output logic          o_Err,
  input  logic          i_Rd_En,
  output logic [7:0]    o_Rd_Byte,
  output logic          o_Rd_Empty,
  output logic          o_RX_Ovf,
  output logic [CW-1:0] o_TX_Count,
  output logic [7:0]    o_TX_Byte,
  output logic          o_TX_DV,
  input  logic          i_TX_Ready,
  input  logic          i_RX_DV,
  input  logic [7:0]    i_RX_Byte
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SEND    = 2'd1;
  localparam logic [1:0] WAIT_RX = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  if (DEPTH < MAX_BYTES_PER_CS || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two no smaller than MAX_BYTES_PER_CS");
  end
  if (TIMEOUT_CLKS < 1) begin : g_bad_timeout
    $error("TIMEOUT_CLKS must be at least 1");
  end

  logic [1:0]    state;
  logic [7:0]    tx_mem [DEPTH];
  logic [7:0]    rx_mem [DEPTH];
  logic [AW-1:0] tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
  logic [AW:0]   tx_cnt, rx_cnt;
  logic [CW-1:0] byte_cnt, byte_cnt_inc;
  logic [31:0]   len_w, occ_w, max_w;
  logic          tx_full, rx_full, rx_empty;
  logic          tx_wr, tx_pop, rx_push_req, rx_push, rx_pop, rx_drop;
  logic          start_ok, progress, timeout;
  logic [AW:0]   tx_discard;

  assign tx_full  = (tx_cnt == FULL_CNT);
  assign rx_full  = (rx_cnt == FULL_CNT);
  assign rx_empty = (rx_cnt == '0);

  assign tx_wr       = i_Wr_DV && !tx_full;
  assign tx_pop      = (state == SEND) && i_TX_Ready;
  assign rx_push_req = (state == WAIT_RX) && i_RX_DV;
  assign rx_push     = rx_push_req && !rx_full;
  assign rx_drop     = rx_push_req && rx_full;
  assign rx_pop      = i_Rd_En && !rx_empty;
  assign progress    = tx_pop || rx_push_req;

  assign byte_cnt_inc = byte_cnt + 1'b1;

  // Lengths are compared at a common width so CW and the occupancy width may differ
  assign len_w    = 32'(i_Len);
  assign occ_w    = 32'(tx_cnt);
  assign max_w    = 32'(MAX_BYTES_PER_CS);
  assign start_ok = (len_w != 32'd0) && (len_w <= max_w) && (occ_w >= len_w);

  assign o_Busy     = (state != IDLE);
  assign o_Wr_Full  = tx_full;
  assign o_Rd_Empty = rx_empty;
  assign o_Rd_Byte  = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr];

`ifdef SPI_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CLKS - 1);

  logic [TW-1:0] to_cnt;

  // Any progress event or timeout is a state change, so the watchdog restarts per byte
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      to_cnt <= '0;
    end else if (!o_Busy || state == DONE || progress || timeout) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign timeout = ((state == SEND) || (state == WAIT_RX)) && !progress && (to_cnt == TO_LAST);

  // In WAIT_RX the in-flight byte has already left the TX buffer
  always_comb begin
    tx_discard = '0;
    if (timeout) begin
      if (state == SEND) tx_discard = (AW + 1)'(o_TX_Count - byte_cnt);
      else               tx_discard = (AW + 1)'(o_TX_Count - byte_cnt - 1'b1);
    end
  end
`else
  assign timeout    = 1'b0;
  assign tx_discard = '0;
`endif

  always_ff @(posedge i_Clk) begin
    if (tx_wr) tx_mem[tx_wr_ptr] <= i_Wr_Byte;
    if (rx_push) rx_mem[rx_wr_ptr] <= i_RX_Byte;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_cnt    <= '0;
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_cnt    <= '0;
      o_RX_Ovf  <= 1'b0;
    end else begin
      tx_wr_ptr <= tx_wr_ptr + AW'(tx_wr);
      tx_rd_ptr <= tx_rd_ptr + AW'(tx_pop) + tx_discard[AW-1:0];
      tx_cnt    <= tx_cnt + (AW + 1)'(tx_wr) - (AW + 1)'(tx_pop) - tx_discard;
      rx_wr_ptr <= rx_wr_ptr + AW'(rx_push);
      rx_rd_ptr <= rx_rd_ptr + AW'(rx_pop);
      rx_cnt    <= rx_cnt + (AW + 1)'(rx_push) - (AW + 1)'(rx_pop);
      o_RX_Ovf  <= o_RX_Ovf | rx_drop;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state      <= IDLE;
      byte_cnt   <= '0;
      o_TX_Count <= '0;
      o_TX_Byte  <= 8'h00;
      o_TX_DV    <= 1'b0;
      o_Done     <= 1'b0;
      o_Err      <= 1'b0;
    end else begin
      o_TX_DV <= tx_pop;
      o_Done  <= 1'b0;
      o_Err   <= timeout;
      if (tx_pop) o_TX_Byte <= tx_mem[tx_rd_ptr];
      case (state)
        IDLE: begin
          if (i_Start) begin
            if (start_ok) begin
              o_TX_Count <= i_Len;
              byte_cnt   <= '0;
              state      <= SEND;
            end else begin
              o_Err <= 1'b1;
            end
          end
        end
        SEND: begin
          if (timeout) state <= IDLE;
          else if (i_TX_Ready) state <= WAIT_RX;
        end
        WAIT_RX: begin
          if (timeout) begin
            state <= IDLE;
          end else if (i_RX_DV) begin
            byte_cnt <= byte_cnt_inc;
            state    <= (byte_cnt_inc == o_TX_Count) ? DONE : SEND;
          end
        end
        default: begin
          o_Done <= 1'b1;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
